// File: rtl/trace_event_scheduler_if.sv
// Record output channel of the trace scheduler.
// Head record plus valid/ready handshake.
`timescale 1ns/1ps
interface trace_event_scheduler_if #(
    parameter int WIDTH = 3,
    parameter int TS_W  = 16
) ();
    logic             out_valid;
    logic             out_ready;
    logic             out_kind;
    logic [TS_W-1:0]  out_time;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_kind,
        output out_time,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_kind,
        input  out_time,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/trace_event_scheduler.sv
// Trace record scheduler: monitor + strobe sources,
// timestamped, one-entry park reg, FWFT record FIFO.
`timescale 1ns/1ps
module trace_event_scheduler #(
    parameter int WIDTH = 3,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mon_en,
    input  logic [WIDTH-1:0]         watch,
    input  logic                     strobe_req,
    input  logic [WIDTH-1:0]         strobe_data,
    trace_event_scheduler_if.master  rec,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_cnt,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic             kind;
        logic [TS_W-1:0]  ts;
        logic [WIDTH-1:0] data;
    } rec_t;

    typedef enum logic [1:0] {OFF, ARM, RUN} state_t;

    state_t           state, state_d;
    logic [TS_W-1:0]  ts_q;
    logic [WIDTH-1:0] prev;
    logic             mon_ev;
    logic             leave;

    rec_t             mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [LW-1:0]    count;

    rec_t             hold, hold_d;
    logic             hold_v, hold_v_d;
    rec_t             wr_rec;
    logic             push, pop, full, can_push, drop;
    rec_t             head;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end

    // Monitor state and baseline value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            prev  <= '0;
        end else begin
            state <= state_d;
            if (state != OFF) prev <= watch;
        end
    end

    // Monitor next state and event detection.
    always_comb begin
        state_d = state;
        mon_ev  = 1'b0;
        leave   = 1'b0;
        unique case (state)
            OFF: if (mon_en) state_d = ARM;
            ARM: begin
                state_d = RUN;
                mon_ev  = 1'b1;
            end
            RUN: begin
                if (!mon_en) begin
                    state_d = OFF;
                    leave   = 1'b1;
                end else if (watch != prev) begin
                    mon_ev = 1'b1;
                end
            end
            default: state_d = OFF;
        endcase
    end

    assign full     = (count == LW'(DEPTH));
    assign pop      = (count != '0) && rec.out_ready;
    assign can_push = !full || pop;

    // Single write port: strobe first, then monitor, then parked record.
    always_comb begin
        push     = 1'b0;
        drop     = 1'b0;
        wr_rec   = '{kind: 1'b1, ts: ts_q, data: strobe_data};
        hold_d   = hold;
        hold_v_d = hold_v;
        if (strobe_req) begin
            if (can_push) push = 1'b1;
            else          drop = 1'b1;
            if (mon_ev) begin
                hold_v_d = 1'b1;
                hold_d   = '{kind: 1'b0, ts: ts_q, data: watch};
            end
        end else if (mon_ev) begin
            if (can_push) begin
                push     = 1'b1;
                wr_rec   = '{kind: 1'b0, ts: ts_q, data: watch};
                hold_v_d = 1'b0;
            end else begin
                hold_v_d = 1'b1;
                hold_d   = '{kind: 1'b0, ts: ts_q, data: watch};
            end
        end else if (hold_v && can_push && !leave) begin
            push     = 1'b1;
            wr_rec   = hold;
            hold_v_d = 1'b0;
        end
        if (leave) hold_v_d = 1'b0;
    end

    // Parked monitor record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v <= 1'b0;
            hold   <= '0;
        end else begin
            hold_v <= hold_v_d;
            hold   <= hold_d;
        end
    end

    // Record storage; contents are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_rec;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Drop accounting, saturating counter plus sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign head          = mem[rptr];
    assign rec.out_valid = (count != '0);
    assign rec.out_kind  = rec.out_valid ? head.kind : 1'b0;
    assign rec.out_time  = rec.out_valid ? head.ts   : '0;
    assign rec.out_data  = rec.out_valid ? head.data : '0;
    assign fifo_level    = count;
endmodule

// File: tb/tb_trace_event_scheduler.sv
// Scoreboard bench for trace_event_scheduler.
// Stimulus pushes expected records; monitor pops on handshake.
`timescale 1ns/1ps
module tb_trace_event_scheduler;
    typedef struct packed {
        logic        kind;
        logic [15:0] ts;
        logic [2:0]  data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mon_en;
    logic [2:0] watch;
    logic       strobe_req;
    logic [2:0] strobe_data;
    logic [2:0] fifo_level;
    logic [7:0] drop_cnt;
    logic       overflow;

    int         checks = 0;
    int         failures = 0;
    int         cyc;
    int         c;
    exp_t       sb [$];

    trace_event_scheduler_if #(.WIDTH(3), .TS_W(16)) rec_if ();

    trace_event_scheduler #(.WIDTH(3), .TS_W(16), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mon_en      (mon_en),
        .watch       (watch),
        .strobe_req  (strobe_req),
        .strobe_data (strobe_data),
        .rec         (rec_if),
        .fifo_level  (fifo_level),
        .drop_cnt    (drop_cnt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Bench cycle index: equals the timestamp a record should carry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: compare every accepted record against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rec_if.out_valid && rec_if.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_record got kind=%0d time=%0d data=%0d, none expected",
                         rec_if.out_kind, rec_if.out_time, rec_if.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rec_if.out_kind !== e.kind || rec_if.out_time !== e.ts ||
                    rec_if.out_data !== e.data) begin
                    failures++;
                    $display("FAIL record got kind=%0d time=%0d data=%0d want kind=%0d time=%0d data=%0d",
                             rec_if.out_kind, rec_if.out_time, rec_if.out_data,
                             e.kind, e.ts, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic expect_rec(input logic k, input int t, input int d);
        exp_t e;
        e.kind = k;
        e.ts   = 16'(t);
        e.data = 3'(d);
        sb.push_back(e);
    endtask

    initial begin
        rst_n       = 1'b0;
        mon_en      = 1'b0;
        watch       = 3'b000;
        strobe_req  = 1'b0;
        strobe_data = 3'b000;
        rec_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", int'(rec_if.out_valid), 0);
        chk("rst_kind", int'(rec_if.out_kind), 0);
        chk("rst_time", int'(rec_if.out_time), 0);
        chk("rst_data", int'(rec_if.out_data), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rec_if.out_ready = 1'b1;

        // 1: enable monitor, initial print at time 5
        while (cyc != 4) tick();
        mon_en = 1'b1;
        expect_rec(1'b0, 5, 0);
        repeat (8) tick();
        chk("t1_level", int'(fifo_level), 0);
        chk("t1_drained", sb.size(), 0);

        // 2: toggle 000->001->000
        c = cyc;
        watch = 3'b001;
        expect_rec(1'b0, c, 1);
        tick();
        watch = 3'b000;
        expect_rec(1'b0, c + 1, 0);
        repeat (4) tick();
        chk("t2_drained", sb.size(), 0);

        // 3: strobe and watch change together
        c = cyc;
        strobe_req  = 1'b1;
        strobe_data = 3'd5;
        watch       = 3'b011;
        expect_rec(1'b1, c, 5);
        expect_rec(1'b0, c, 3);
        tick();
        strobe_req = 1'b0;
        repeat (4) tick();
        chk("t3_level", int'(fifo_level), 0);
        chk("t3_drained", sb.size(), 0);

        // 4: six strobes into a stalled FIFO
        rec_if.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe_req  = 1'b1;
            strobe_data = 3'(i + 1);
            if (i < 4) expect_rec(1'b1, cyc, i + 1);
            tick();
        end
        strobe_req = 1'b0;
        tick();
        chk("t4_level", int'(fifo_level), 4);
        chk("t4_drop", int'(drop_cnt), 2);
        chk("t4_ovf", int'(overflow), 1);
        rec_if.out_ready = 1'b1;
        repeat (6) tick();
        chk("t4_level_after", int'(fifo_level), 0);
        chk("t4_drained", sb.size(), 0);

        // 5: coalescing in the park register while full
        rec_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe_req  = 1'b1;
            strobe_data = 3'(7 - i);
            expect_rec(1'b1, cyc, 7 - i);
            tick();
        end
        strobe_req = 1'b0;
        watch = 3'b001;
        tick();
        c = cyc;
        watch = 3'b010;
        tick();
        tick();
        chk("t5_level", int'(fifo_level), 4);
        chk("t5_drop", int'(drop_cnt), 2);
        expect_rec(1'b0, c, 2);
        rec_if.out_ready = 1'b1;
        repeat (8) tick();
        chk("t5_level_after", int'(fifo_level), 0);
        chk("t5_drop_after", int'(drop_cnt), 2);
        chk("t5_drained", sb.size(), 0);

        // disable: no record on leaving, no records while off
        mon_en = 1'b0;
        watch  = 3'b101;
        tick();
        watch  = 3'b110;
        repeat (4) tick();
        chk("off_level", int'(fifo_level), 0);

        // 6: asynchronous reset mid-drain
        rec_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe_req  = 1'b1;
            strobe_data = 3'(i + 1);
            expect_rec(1'b1, cyc, i + 1);
            tick();
        end
        strobe_req = 1'b0;
        tick();
        chk("t6_level", int'(fifo_level), 3);
        rec_if.out_ready = 1'b1;
        tick();
        chk("t6_level_pop", int'(fifo_level), 2);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_valid", int'(rec_if.out_valid), 0);
        chk("t6_level_rst", int'(fifo_level), 0);
        chk("t6_drop_rst", int'(drop_cnt), 0);
        chk("t6_ovf_rst", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_valid_after", int'(rec_if.out_valid), 0);
        chk("final_sb", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
